axi_lite_master: RTL
====================

# axi_lite_master

AXI4-Lite initiator that turns single-beat commands from local control logic into AXI-Lite write or read transactions on an `m0_axi` port. It is the initiator that drives the team's `s0_axi` register-bus slaves. It handles one transaction at a time and returns the slave's response and read data on a pulsed response port.

## Interface
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, byte address width in bits.

- m0_axi_aclk  in  1  clock; all logic is rising-edge.
- m0_axi_aresetn  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_write  out  1  kind of the completed transaction.
- rsp_resp  out  2  BRESP or RRESP as returned by the slave.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- m0_axi_awaddr/awvalid (out), awready (in): write address channel.
- m0_axi_wdata (out, DATA_WIDTH), wstrb (out, DATA_WIDTH/8), wvalid (out), wready (in): write data channel.
- m0_axi_bresp (in, 2), bvalid (in), bready (out): write response channel.
- m0_axi_araddr/arvalid (out), arready (in): read address channel.
- m0_axi_rdata (in, DATA_WIDTH), rresp (in, 2), rvalid (in), rready (out): read data channel.

## Operation
- All outputs are registered.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch addr, wdata, wstrb and write.
  - Write → WR_ADDR with awvalid = wvalid = 1.
  - Read → RD_ADDR with arvalid = 1.
  - cmd_ready drops the same edge.
- WR_ADDR:
  - awvalid and wvalid are tracked independently.
  - Each clears on the edge where its own handshake occurs (valid && ready). The other stays asserted.
  - Once both handshakes have occurred, go to WR_RESP with bready = 1. This includes both in the same cycle.
  - awaddr, wdata and wstrb stay stable while their valid is high.
- WR_RESP: on bvalid && bready, capture bresp, clear bready and go to IDLE. Next cycle: rsp_valid = 1, rsp_write = 1, rsp_rdata = 0.
- RD_ADDR: on arvalid && arready, clear arvalid and go to RD_DATA with rready = 1.
- RD_DATA: on rvalid && rready, capture rdata and rresp, clear rready and go to IDLE. Next cycle: rsp_valid = 1, rsp_write = 0.
- Transfers are single-beat only. No outstanding transactions overlap.
- The response port has no backpressure. The consumer must take rsp_* in the rsp_valid cycle.
- rsp_resp, rsp_rdata and rsp_write hold their values until the next completion.
- Valids never depend combinationally on readies. Once asserted, a valid is not withdrawn before its handshake.

## Timing
- Reset (aresetn low, asynchronous):
  - State = IDLE.
  - cmd_ready, rsp_valid, rsp_write, awvalid, wvalid, bready, arvalid and rready all = 0.
  - rsp_resp, rsp_rdata and all address, data and strobe outputs = 0.
  - cmd_ready rises on the first clock edge after release.
- Command accepted at edge 0:
  - AW/W/AR valid is high during cycle 1.
  - With zero-wait slaves, bready/rready is high in cycle 2.
  - rsp_valid is high in cycle 3.
  - cmd_ready is high again in cycle 3. A new command can be accepted at edge 3.
- Minimum of 3 cycles per transaction; each slave wait cycle adds one cycle.
- awready before wready, or the reverse: the earlier channel deasserts its valid and waits. WR_RESP is entered only after the later handshake.
- bvalid or rvalid already high on entry to WR_RESP/RD_DATA: the handshake completes in the first cycle.
- cmd_valid while busy: ignored. The caller holds it until cmd_ready.
- Reset mid-transaction: all valids and readies drop immediately. The pending transaction is abandoned and no rsp_valid is produced.

## Test plan
- Write, zero-wait slave:
  - Stimulus: cmd addr 0x10, wdata 0xDEADBEEF, wstrb 0xF.
  - Response: awaddr 0x10 and wdata 0xDEADBEEF with both valids in cycle 1, bready in cycle 2, rsp_valid in cycle 3 with rsp_resp 2'b00 and rsp_write 1.
- Skewed write handshakes:
  - Stimulus: wready high immediately, awready delayed 3 cycles.
  - Response: wvalid high exactly 1 cycle; awvalid held 4 cycles with awaddr stable; bready only after the AW handshake.
- Read with wait:
  - Stimulus: cmd addr 0x04; slave raises rvalid 2 cycles after rready with rdata 0x12345678 and rresp 00.
  - Response: one rsp_valid pulse with rsp_rdata 0x12345678 and rsp_write 0.
- Error propagation:
  - Stimulus: bresp 2'b10 on a write, then rresp 2'b11 on a read.
  - Response: rsp_resp 2'b10, then 2'b11.
- Back-to-back commands:
  - Stimulus: cmd_valid held high with a write then a read queued.
  - Response: the second command is accepted exactly in the cycle rsp_valid pulses; no channel valids overlap between the two transactions.
- Reset mid-operation:
  - Stimulus: assert aresetn low while awvalid is pending.
  - Response: all outputs 0 asynchronously; no rsp_valid; cmd_ready 1 one edge after release; the next write completes normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master: AXI4-Lite initiator, one single-beat transaction at a time.
// Turns a local command (cmd_*) into an AXI-Lite write or read on m0_axi and
// returns the slave response on a one-cycle rsp_* pulse.
// Ports:
//   m0_axi_aclk / m0_axi_aresetn : clock, async active-low reset
//   cmd_*                        : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                        : completion pulse (valid, write, resp, rdata)
//   m0_axi_aw*/w*/b*/ar*/r*      : AXI4-Lite master channels
// All outputs are registered; valids never depend combinationally on readies.
module axi_lite_master #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                      m0_axi_aclk,
   input  logic                      m0_axi_aresetn,
   // command port
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response port
   output logic                      rsp_valid,
   output logic                      rsp_write,
   output logic [1:0]                rsp_resp,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   // write address channel
   output logic [ADDR_WIDTH-1:0]     m0_axi_awaddr,
   output logic                      m0_axi_awvalid,
   input  logic                      m0_axi_awready,
   // write data channel
   output logic [DATA_WIDTH-1:0]     m0_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m0_axi_wstrb,
   output logic                      m0_axi_wvalid,
   input  logic                      m0_axi_wready,
   // write response channel
   input  logic [1:0]                m0_axi_bresp,
   input  logic                      m0_axi_bvalid,
   output logic                      m0_axi_bready,
   // read address channel
   output logic [ADDR_WIDTH-1:0]     m0_axi_araddr,
   output logic                      m0_axi_arvalid,
   input  logic                      m0_axi_arready,
   // read data channel
   input  logic [DATA_WIDTH-1:0]     m0_axi_rdata,
   input  logic [1:0]                m0_axi_rresp,
   input  logic                      m0_axi_rvalid,
   output logic                      m0_axi_rready
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic                    cmd_ready_d;
   logic                    rsp_valid_d;
   logic                    rsp_write_d;
   logic [1:0]              rsp_resp_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_d;
   logic [ADDR_WIDTH-1:0]   awaddr_d;
   logic                    awvalid_d;
   logic [DATA_WIDTH-1:0]   wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_d;
   logic                    wvalid_d;
   logic                    bready_d;
   logic [ADDR_WIDTH-1:0]   araddr_d;
   logic                    arvalid_d;
   logic                    rready_d;

   // State and output registers
   always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
      if (!m0_axi_aresetn) begin
         state_q        <= IDLE;
         cmd_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_write      <= 1'b0;
         rsp_resp       <= 2'b00;
         rsp_rdata      <= '0;
         m0_axi_awaddr  <= '0;
         m0_axi_awvalid <= 1'b0;
         m0_axi_wdata   <= '0;
         m0_axi_wstrb   <= '0;
         m0_axi_wvalid  <= 1'b0;
         m0_axi_bready  <= 1'b0;
         m0_axi_araddr  <= '0;
         m0_axi_arvalid <= 1'b0;
         m0_axi_rready  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_ready      <= cmd_ready_d;
         rsp_valid      <= rsp_valid_d;
         rsp_write      <= rsp_write_d;
         rsp_resp       <= rsp_resp_d;
         rsp_rdata      <= rsp_rdata_d;
         m0_axi_awaddr  <= awaddr_d;
         m0_axi_awvalid <= awvalid_d;
         m0_axi_wdata   <= wdata_d;
         m0_axi_wstrb   <= wstrb_d;
         m0_axi_wvalid  <= wvalid_d;
         m0_axi_bready  <= bready_d;
         m0_axi_araddr  <= araddr_d;
         m0_axi_arvalid <= arvalid_d;
         m0_axi_rready  <= rready_d;
      end
   end

   // Next-state and next-output logic; every register holds unless changed below
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write;
      rsp_resp_d  = rsp_resp;
      rsp_rdata_d = rsp_rdata;
      awaddr_d    = m0_axi_awaddr;
      awvalid_d   = m0_axi_awvalid;
      wdata_d     = m0_axi_wdata;
      wstrb_d     = m0_axi_wstrb;
      wvalid_d    = m0_axi_wvalid;
      bready_d    = m0_axi_bready;
      araddr_d    = m0_axi_araddr;
      arvalid_d   = m0_axi_arvalid;
      rready_d    = m0_axi_rready;

      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_ADDR;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end

         // AW and W retire independently; leave only when both have handshaken
         WR_ADDR: begin
            if (m0_axi_awvalid && m0_axi_awready) awvalid_d = 1'b0;
            if (m0_axi_wvalid && m0_axi_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end

         WR_RESP: begin
            if (m0_axi_bvalid && m0_axi_bready) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_resp_d  = m0_axi_bresp;
               rsp_rdata_d = '0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         RD_ADDR: begin
            if (m0_axi_arvalid && m0_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end

         RD_DATA: begin
            if (m0_axi_rvalid && m0_axi_rready) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_resp_d  = m0_axi_rresp;
               rsp_rdata_d = m0_axi_rdata;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
